// File: rtl/sa_iport_req.sv
// sa_iport_req: per-input-port matrix arbiter feeding the switch allocator and registering ST control
module sa_iport_req #(
  parameter int N = 5,
  parameter int V = 4,
  parameter int VW = 2,
  parameter int LOCK_PKT = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [V-1:0]   vc_valid,
  input  logic [V*N-1:0] vc_outport,
  input  logic [V-1:0]   vc_credit_ok,
  input  logic [V-1:0]   vc_tail,
  output logic [N-1:0]   reqSA,
  input  logic           inputGrantSA,
  output logic [V-1:0]   vc_pop,
  output logic           st_valid,
  output logic [VW-1:0]  st_vc,
  output logic [N-1:0]   st_outport,
  output logic [V-1:0]   vc_release
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state_q, state_d;
  logic [V-1:0][V-1:0] pri_q;
  logic [VW-1:0] lock_vc, grant_idx;
  logic [V-1:0] lock_mask, eligible, beaten, winner, grant;
  logic tail_grant, any_grant;
  always_ff @(posedge clk)
    state_q <= rst ? IDLE : state_d;
  always_comb begin
    state_d = state_q;
    if (LOCK_PKT == 0)
      state_d = IDLE;
    else if (state_q == IDLE)
      state_d = (any_grant && !tail_grant) ? LOCKED : IDLE;
    else
      state_d = tail_grant ? IDLE : LOCKED;
  end
  always_comb
    lock_mask = (state_q == LOCKED) ? (V'(1) << lock_vc) : '1;
  assign eligible = vc_valid & vc_credit_ok & lock_mask & ~{V{rst}};
  always_comb begin
    beaten = '0;
    for (int v = 0; v < V; v++)
      for (int u = 0; u < V; u++)
        beaten[v] = beaten[v] | (eligible[u] & pri_q[u][v]);
  end
  assign winner = eligible & ~beaten;
  always_comb begin
    reqSA = '0;
    for (int v = 0; v < V; v++)
      reqSA = reqSA | (winner[v] ? vc_outport[v*N +: N] : '0);
  end
  assign grant = winner & {V{inputGrantSA & |reqSA}};
  assign vc_pop = grant;
  assign any_grant = |grant;
  assign tail_grant = |(grant & vc_tail);
  always_comb begin
    grant_idx = '0;
    for (int v = 0; v < V; v++)
      grant_idx = grant_idx | (grant[v] ? VW'(v) : '0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < V; i++)
        for (int j = 0; j < V; j++)
          pri_q[i][j] <= (i < j);
    end else if ((LOCK_PKT != 0) ? tail_grant : any_grant) begin
      for (int i = 0; i < V; i++)
        for (int j = 0; j < V; j++)
          pri_q[i][j] <= grant[i] ? 1'b0 : grant[j] ? 1'b1 : pri_q[i][j];
    end
  end
  always_ff @(posedge clk) begin
    if (rst)
      lock_vc <= '0;
    else if (LOCK_PKT != 0 && state_q == IDLE && any_grant && !tail_grant)
      lock_vc <= grant_idx;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_valid   <= 1'b0;
      st_vc      <= '0;
      st_outport <= '0;
      vc_release <= '0;
    end else begin
      st_valid   <= any_grant;
      st_vc      <= grant_idx;
      st_outport <= any_grant ? reqSA : '0;
      vc_release <= grant & vc_tail;
    end
  end
  assert property (@(posedge clk) disable iff (rst) !(inputGrantSA && ~|reqSA))
    else $warning("sa_iport_req: grant without request ignored");
endmodule

// File: tb/tb_sa_iport_req.sv
// tb_sa_iport_req: directed scoreboard bench for flit-by-flit and packet-locked instances
module tb_sa_iport_req;
  logic clk = 1'b0, rst = 1'b1, gnt = 1'b0;
  logic [3:0] vc_valid = '0, vc_credit_ok = '0, vc_tail = '0;
  logic [19:0] vc_outport = '0;
  logic [4:0] req0, req1, sop0, sop1;
  logic [3:0] pop0, pop1, rel0, rel1;
  logic [1:0] svc0, svc1;
  logic sv0, sv1;
  int checks = 0, errors = 0;
  typedef struct {logic sv; logic [1:0] vc; logic [4:0] op; logic [3:0] rel;} st_t;
  st_t sb[$];
  always #5 clk = ~clk;
  sa_iport_req #(.LOCK_PKT(0)) dut0 (
    .clk(clk), .rst(rst), .vc_valid(vc_valid), .vc_outport(vc_outport),
    .vc_credit_ok(vc_credit_ok), .vc_tail(vc_tail), .reqSA(req0), .inputGrantSA(gnt),
    .vc_pop(pop0), .st_valid(sv0), .st_vc(svc0), .st_outport(sop0), .vc_release(rel0)
  );
  sa_iport_req #(.LOCK_PKT(1)) dut1 (
    .clk(clk), .rst(rst), .vc_valid(vc_valid), .vc_outport(vc_outport),
    .vc_credit_ok(vc_credit_ok), .vc_tail(vc_tail), .reqSA(req1), .inputGrantSA(gnt),
    .vc_pop(pop1), .st_valid(sv1), .st_vc(svc1), .st_outport(sop1), .vc_release(rel1)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step(input bit r, input bit lk, input logic [3:0] va, input logic [3:0] cr,
                      input logic [3:0] tl, input logic [19:0] op, input bit g,
                      input logic [4:0] er, input logic [3:0] ep);
    st_t e;
    rst = r; vc_valid = va; vc_credit_ok = cr; vc_tail = tl; vc_outport = op; gnt = g;
    #1;
    chk("reqSA", lk ? req1 : req0, er);
    chk("vc_pop", lk ? pop1 : pop0, ep);
    e.sv = |ep;
    e.vc = ep[3] ? 2'd3 : ep[2] ? 2'd2 : ep[1] ? 2'd1 : 2'd0;
    e.op = e.sv ? er : 5'd0;
    e.rel = ep & tl;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("st_valid", lk ? sv1 : sv0, e.sv);
    chk("st_vc", lk ? svc1 : svc0, e.vc);
    chk("st_outport", lk ? sop1 : sop0, e.op);
    chk("vc_release", lk ? rel1 : rel0, e.rel);
  endtask
  localparam logic [19:0] OPA = {4{5'b00010}};
  localparam logic [19:0] OPB = {5'b0, 5'b10000, 5'b0, 5'b0};
  localparam logic [19:0] OPC = {5'b0, 5'b0, 5'b00100, 5'b00001};
  localparam logic [19:0] OPD = {5'b01000, 5'b0, 5'b00100, 5'b0};
  initial begin
    step(1, 0, 4'b1111, 4'b1111, 4'b0000, OPA, 1, 5'b0, 4'b0);
    step(0, 0, 4'b1111, 4'b1111, 4'b0000, OPA, 1, 5'b00010, 4'b0001);
    step(0, 0, 4'b1111, 4'b1111, 4'b0000, OPA, 1, 5'b00010, 4'b0010);
    step(0, 0, 4'b1111, 4'b1111, 4'b0000, OPA, 1, 5'b00010, 4'b0100);
    step(0, 0, 4'b1111, 4'b1111, 4'b0000, OPA, 1, 5'b00010, 4'b1000);
    step(0, 0, 4'b1111, 4'b1111, 4'b0000, OPA, 1, 5'b00010, 4'b0001);
    step(1, 0, 4'b1111, 4'b1111, 4'b0000, OPA, 1, 5'b0, 4'b0);
    step(0, 0, 4'b1111, 4'b1111, 4'b0000, OPA, 1, 5'b00010, 4'b0001);
    step(1, 0, 4'b0000, 4'b1111, 4'b0000, OPB, 0, 5'b0, 4'b0);
    step(0, 0, 4'b0100, 4'b1111, 4'b0000, OPB, 0, 5'b10000, 4'b0);
    step(0, 0, 4'b0100, 4'b1111, 4'b0000, OPB, 0, 5'b10000, 4'b0);
    step(0, 0, 4'b0100, 4'b1111, 4'b0000, OPB, 0, 5'b10000, 4'b0);
    step(0, 0, 4'b0100, 4'b1111, 4'b0000, OPB, 1, 5'b10000, 4'b0100);
    step(1, 0, 4'b0000, 4'b1111, 4'b0000, OPA, 0, 5'b0, 4'b0);
    step(0, 0, 4'b0011, 4'b1111, 4'b0011, OPA, 1, 5'b00010, 4'b0001);
    step(0, 0, 4'b0011, 4'b1111, 4'b0011, OPA, 1, 5'b00010, 4'b0010);
    step(0, 0, 4'b0000, 4'b1111, 4'b0000, OPA, 1, 5'b0, 4'b0);
    step(1, 1, 4'b0000, 4'b1111, 4'b0000, OPC, 0, 5'b0, 4'b0);
    step(0, 1, 4'b0010, 4'b1111, 4'b0000, OPC, 1, 5'b00100, 4'b0010);
    step(0, 1, 4'b0011, 4'b1111, 4'b0000, OPC, 1, 5'b00100, 4'b0010);
    step(0, 1, 4'b0011, 4'b1111, 4'b0010, OPC, 1, 5'b00100, 4'b0010);
    step(0, 1, 4'b0011, 4'b1111, 4'b0000, OPC, 1, 5'b00001, 4'b0001);
    step(1, 1, 4'b0011, 4'b1111, 4'b0001, OPC, 1, 5'b0, 4'b0);
    step(0, 1, 4'b0010, 4'b1111, 4'b0000, OPC, 1, 5'b00100, 4'b0010);
    step(1, 1, 4'b0000, 4'b1111, 4'b0000, OPD, 0, 5'b0, 4'b0);
    step(0, 1, 4'b1010, 4'b1111, 4'b0000, OPD, 1, 5'b00100, 4'b0010);
    step(0, 1, 4'b1010, 4'b0101, 4'b0000, OPD, 1, 5'b0, 4'b0);
    step(0, 1, 4'b1010, 4'b0101, 4'b0000, OPD, 1, 5'b0, 4'b0);
    step(0, 1, 4'b1010, 4'b1111, 4'b0010, OPD, 1, 5'b00100, 4'b0010);
    step(0, 1, 4'b1010, 4'b1111, 4'b0000, OPD, 1, 5'b01000, 4'b1000);
    step(1, 0, 4'b0000, 4'b1111, 4'b0000, OPA, 0, 5'b0, 4'b0);
    step(0, 0, 4'b0001, 4'b1111, 4'b0000, OPA, 1, 5'b00010, 4'b0001);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
